// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  // True when any address bit above the memory word-address width is set.
  function automatic logic addr_out_of_range(input logic [WORD_W-1:0] addr,
                                             input int unsigned       addr_w);
    return ((addr >> addr_w) != {WORD_W{1'b0}});
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requesters, plus the next value
// of the data-grant streak counter assuming a grant is made this cycle.
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int MAX_STREAK = 4,
  parameter int SW         = $clog2(MAX_STREAK + 1)
) (
  input  logic          i_if_req,
  input  logic          i_d_req,
  input  logic [SW-1:0] i_streak,
  output logic          o_gnt_valid,
  output logic          o_gnt,
  output logic [SW-1:0] o_streak_nxt
);

  logic w_sat;

  assign w_sat = (i_streak == SW'(MAX_STREAK));

  // Data wins unless a pending fetch has already waited out a full streak.
  always_comb begin
    o_gnt_valid  = i_if_req | i_d_req;
    o_gnt        = GNT_IF;
    o_streak_nxt = i_streak;
    if (i_d_req && !(i_if_req && w_sat)) begin
      o_gnt = GNT_D;
      if (i_if_req) begin
        o_streak_nxt = w_sat ? i_streak : (i_streak + SW'(1));
      end else begin
        o_streak_nxt = {SW{1'b0}};
      end
    end else if (i_if_req) begin
      o_gnt        = GNT_IF;
      o_streak_nxt = {SW{1'b0}};
    end else begin
      o_gnt        = GNT_IF;
      o_streak_nxt = i_streak;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between instruction fetch and data
// accesses. Each access runs IDLE -> BUSY (MEM_LAT cycles) -> RESP; out of
// range addresses bypass the memory and respond with err set.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W     = 10,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_gnt;
  logic [LW-1:0]       r_lat_cnt;
  logic [SW-1:0]       r_streak;
  logic [SW-1:0]       w_streak_nxt;
  logic                w_gnt_valid;
  logic                w_gnt;
  logic [WORD_W-1:0]   w_sel_addr;
  logic                w_sel_err;
  logic                w_lat_done;

  logic                r_if_ready;
  logic [WORD_W-1:0]   r_if_rdata;
  logic                r_if_err;
  logic                r_d_ready;
  logic [WORD_W-1:0]   r_d_rdata;
  logic                r_d_err;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;

  mem_arb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_pick (
    .i_if_req     (if_req),
    .i_d_req      (d_req),
    .i_streak     (r_streak),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt        (w_gnt),
    .o_streak_nxt (w_streak_nxt)
  );

  assign w_sel_addr = (w_gnt == GNT_D) ? d_addr : if_addr;
  assign w_sel_err  = addr_out_of_range(w_sel_addr, ADDR_W);
  assign w_lat_done = (r_lat_cnt == {LW{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: errors skip the memory cycle, RESP never grants.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = w_sel_err ? RESP : BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (w_lat_done) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant latch, memory drive, latency count and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt       <= GNT_IF;
      r_lat_cnt   <= {LW{1'b0}};
      r_streak    <= {SW{1'b0}};
      r_if_ready  <= 1'b0;
      r_if_rdata  <= {WORD_W{1'b0}};
      r_if_err    <= 1'b0;
      r_d_ready   <= 1'b0;
      r_d_rdata   <= {WORD_W{1'b0}};
      r_d_err     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {WORD_W{1'b0}};
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gnt    <= w_gnt;
            r_streak <= w_streak_nxt;
            if (w_sel_err) begin
              // Respond straight away; memory is never touched.
              if (w_gnt == GNT_D) begin
                r_d_ready <= 1'b1;
                r_d_err   <= 1'b1;
                r_d_rdata <= {WORD_W{1'b0}};
              end else begin
                r_if_ready <= 1'b1;
                r_if_err   <= 1'b1;
                r_if_rdata <= {WORD_W{1'b0}};
              end
            end else begin
              r_mem_en    <= 1'b1;
              r_mem_we    <= (w_gnt == GNT_D) ? d_we : 1'b0;
              r_mem_addr  <= w_sel_addr[ADDR_W-1:0];
              r_mem_wdata <= (w_gnt == GNT_D) ? d_wdata : {WORD_W{1'b0}};
              r_lat_cnt   <= LAT_LOAD;
            end
          end
        end
        BUSY: begin
          if (w_lat_done) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_gnt == GNT_D) begin
              r_d_ready <= 1'b1;
              r_d_err   <= 1'b0;
              if (!r_mem_we) begin
                r_d_rdata <= mem_rdata;
              end
            end else begin
              r_if_ready <= 1'b1;
              r_if_err   <= 1'b0;
              r_if_rdata <= mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
          end
        end
        RESP: begin
          r_mem_en <= 1'b0;
        end
        default: begin
          r_mem_en <= 1'b0;
        end
      endcase
    end
  end

  assign if_ready  = r_if_ready;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign d_ready   = r_d_ready;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
